// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and the hex font for the seven-segment scan controller.
// Optional dimming is enabled by defining SEVEN_SEG_DIM_EN.
package seven_seg_pkg;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between a data source and the scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int NDIG = 4
) ();
    logic                load_valid;
    logic                load_ready;
    logic [4*NDIG-1:0]   load_data;

    modport master (output load_valid, output load_data, input  load_ready);
    modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to seven-segment pattern.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = hex2seg(i_nib);
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed hex display scanner with blanking gaps and frame-aligned data commit.
// Define SEVEN_SEG_DIM_EN to add the dim[1:0] on-time control input.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = 7500,
    parameter int BLANK = 16,
    parameter int CBITS = 13
) (
    input  logic              clk,
    input  logic              rst,
    seven_seg_scan_ctrl_if.slave ld,
    input  logic [NDIG-1:0]   digit_en,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [1:0]        dim,
`endif
    output logic [6:0]        segment,
    output logic [NDIG-1:0]   anode,
    output logic              sig,
    output logic              frame_tick
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e             r_state, w_nxt_state;
    logic [CBITS-1:0]   r_cnt, w_nxt_cnt;
    logic [IW-1:0]      r_idx, w_nxt_idx;
    logic               r_en_q, w_nxt_en;
    logic [4*NDIG-1:0]  r_shadow, r_pending;
    logic               r_full;
    logic               w_on, w_end;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;
`ifdef SEVEN_SEG_DIM_EN
    logic [1:0]         r_dim_q, w_nxt_dim;
`endif

    assign ld.load_ready = ~r_full;
    assign w_nib         = r_shadow[4*r_idx +: 4];

    seven_seg_decode u_dec (.i_nib(w_nib), .o_seg(w_seg));

    // Next-state view lets every output register reflect the state being entered.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_nxt_idx   = r_idx;
        w_nxt_en    = r_en_q;
`ifdef SEVEN_SEG_DIM_EN
        w_nxt_dim   = r_dim_q;
`endif
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CBITS'(BLANK-1)) begin
                    w_nxt_state = ST_SHOW;
                    w_nxt_cnt   = '0;
                    w_nxt_en    = digit_en[r_idx];
`ifdef SEVEN_SEG_DIM_EN
                    w_nxt_dim   = dim;
`endif
                end
            end
            default: begin
                if (r_cnt == CBITS'(DWELL-1)) begin
                    w_nxt_state = ST_BLANK;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = (r_idx == IW'(NDIG-1)) ? '0 : r_idx + 1'b1;
                end
            end
        endcase
        w_end = (w_nxt_state == ST_SHOW) && (w_nxt_cnt == CBITS'(DWELL-1));
        w_on  = (w_nxt_state == ST_SHOW) && w_nxt_en;
`ifdef SEVEN_SEG_DIM_EN
        w_on  = w_on && (int'(w_nxt_cnt) < (int'(w_nxt_dim) + 1) * (DWELL/4));
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_en_q     <= 1'b0;
            r_shadow   <= '0;
            r_pending  <= '0;
            r_full     <= 1'b0;
            segment    <= SEG_OFF;
            anode      <= '0;
            sig        <= 1'b0;
            frame_tick <= 1'b0;
`ifdef SEVEN_SEG_DIM_EN
            r_dim_q    <= '0;
`endif
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_idx      <= w_nxt_idx;
            r_en_q     <= w_nxt_en;
            anode      <= w_on ? (NDIG'(1) << r_idx) : '0;
            segment    <= w_on ? w_seg : SEG_OFF;
            sig        <= w_end;
            frame_tick <= w_end && (r_idx == IW'(NDIG-1));
`ifdef SEVEN_SEG_DIM_EN
            r_dim_q    <= w_nxt_dim;
`endif
            // Commit needs a full buffer and accept needs an empty one, so they never collide.
            if (frame_tick && r_full) begin
                r_shadow <= r_pending;
                r_full   <= 1'b0;
            end
            if (ld.load_valid && !r_full) begin
                r_pending <= ld.load_data;
                r_full    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a time-based display model.
module tb_seven_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
`ifdef SEVEN_SEG_DIM_EN
    localparam bit DIM_ON = 1'b1;
`else
    localparam bit DIM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NDIG-1:0] digit_en = '0;
    logic [1:0] dim = '0;
    logic [6:0] segment;
    logic [NDIG-1:0] anode;
    logic sig, frame_tick;

    seven_seg_scan_ctrl_if #(.NDIG(NDIG)) ld_if ();

    seven_seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK), .CBITS(4)) dut (
        .clk(clk), .rst(rst), .ld(ld_if), .digit_en(digit_en),
`ifdef SEVEN_SEG_DIM_EN
        .dim(dim),
`endif
        .segment(segment), .anode(anode), .sig(sig), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_tests = 0;
    int n_fail  = 0;
    // Display model: cycle index since reset release, committed/pending words, per-slot latches.
    int          mc = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_pend = '0;
    logic        m_full = 1'b0;
    logic        m_en = 1'b0;
    logic [1:0]  m_dim = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, mc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic [15:0] d, input logic [3:0] en, input logic [1:0] dm);
        int p, s;
        logic old_full;
        p = mc % SLOT;
        s = (mc / SLOT) % NDIG;
        old_full = m_full;
        if (p == SLOT-1 && s == NDIG-1 && old_full) begin
            m_shadow = m_pend;
            m_full   = 1'b0;
        end
        if (v && !old_full) begin
            m_pend = d;
            m_full = 1'b1;
        end
        if (p == BLANK-1) begin
            m_en  = en[s];
            m_dim = dm;
        end
        mc++;
    endtask

    task automatic check_outputs();
        int p, s, k, lim;
        logic on;
        logic [3:0] ea;
        logic [6:0] es;
        p   = mc % SLOT;
        s   = (mc / SLOT) % NDIG;
        k   = p - BLANK;
        lim = DIM_ON ? (int'(m_dim) + 1) * (DWELL/4) : DWELL;
        on  = (p >= BLANK) && m_en && (k < lim);
        ea  = on ? (4'b0001 << s) : 4'b0000;
        es  = on ? font[m_shadow[4*s +: 4]] : 7'h00;
        chk("anode", 32'(anode), 32'(ea));
        chk("segment", 32'(segment), 32'(es));
        chk("sig", 32'(sig), 32'(p == SLOT-1));
        chk("frame_tick", 32'(frame_tick), 32'(p == SLOT-1 && s == NDIG-1));
        chk("load_ready", 32'(ld_if.load_ready), 32'(!m_full));
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] en, input logic [1:0] dm);
        ld_if.load_valid = v;
        ld_if.load_data  = d;
        digit_en = en;
        dim      = dm;
        @(posedge clk);
        model_edge(v, d, en, dm);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_state();
        chk("rst_anode", 32'(anode), 32'h0);
        chk("rst_segment", 32'(segment), 32'h0);
        chk("rst_sig", 32'(sig), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        chk("rst_load_ready", 32'(ld_if.load_ready), 32'h1);
    endtask

    initial begin
        logic [15:0] d;
        int guard;
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        // Idle scan of zeros, then a single-cycle load at cycle 5.
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 4'hF, 2'd3);
        cyc(1'b1, 16'h8421, 4'hF, 2'd3);
        for (int i = 0; i < 90; i++) cyc(1'b0, 16'h0, 4'hF, 2'd3);

        // Source holds valid and data until accepted.
        d = 16'($urandom);
        for (int i = 0; i < 130; i++) begin
            logic acc;
            acc = !m_full;
            cyc(1'b1, d, 4'hF, 2'd3);
            if (acc) d = 16'($urandom);
        end

        // Accept exactly on a frame_tick cycle with the pending buffer empty.
        guard = 0;
        while (!(!m_full && (mc % SLOT) == SLOT-1 && ((mc / SLOT) % NDIG) == NDIG-1) && guard < 200) begin
            cyc(1'b0, 16'h0, 4'hF, 2'd3);
            guard++;
        end
        chk("frame_tick_align_timeout", 32'(guard < 200), 32'h1);
        cyc(1'b1, 16'hC0DE, 4'hF, 2'd3);
        for (int i = 0; i < 85; i++) cyc(1'b0, 16'h0, 4'hF, 2'd3);

        // Static digit mask, then random masks and loads changing mid-slot.
        for (int i = 0; i < 80; i++) cyc(1'b0, 16'h0, 4'b0101, 2'd3);
        for (int i = 0; i < 240; i++)
            cyc(1'($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), 2'($urandom));

`ifdef SEVEN_SEG_DIM_EN
        for (int i = 0; i < 40; i++) cyc(1'b0, 16'h0, 4'hF, 2'd1);
`endif

        // Load at start of a frame, then reset mid-SHOW of digit 2 with pending still full.
        guard = 0;
        while (!(!m_full && (mc % (SLOT*NDIG)) == 0) && guard < 200) begin
            cyc(1'b0, 16'h0, 4'hF, 2'd3);
            guard++;
        end
        chk("frame_start_timeout", 32'(guard < 200), 32'h1);
        cyc(1'b1, 16'h5A5A, 4'hF, 2'd3);
        while ((mc % (SLOT*NDIG)) != 2*SLOT + BLANK + 3) cyc(1'b0, 16'h0, 4'hF, 2'd3);
        chk("pending_full_before_reset", 32'(ld_if.load_ready), 32'h0);
        #3 rst = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        rst = 1'b1;
        mc = 0; m_shadow = '0; m_pend = '0; m_full = 1'b0; m_en = 1'b0; m_dim = '0;
        for (int i = 0; i < 50; i++) cyc(1'b0, 16'h0, 4'hF, 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Scan scheduler that time-multiplexes NDIG hex digits onto one shared 7-bit segment bus. It drives a one-hot digit-select (anode) vector and inserts a blanking gap between digits to suppress ghosting. New display data arrives via a valid/ready handshake into a pending buffer. The pending buffer is committed only at a frame boundary, so a frame never mixes old and new data.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
DWELL, 7500, cycles each digit is shown per slot
BLANK, 16, cycles of all-off gap before each digit slot
CBITS, 13, width of slot counter; must hold max(DWELL, BLANK)-1

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
load_valid  input  1  load_data is valid
load_ready  output  1  pending buffer empty, load accepted when valid&ready
load_data  input  4*NDIG  hex nibbles; digit i = load_data[4*i+3:4*i]
digit_en  input  NDIG  per-digit enable; sampled each slot start
segment  output  7  active-high segments {g,f,e,d,c,b,a}
anode  output  NDIG  one-hot active-high digit select, 0 during blank
sig  output  1  one-cycle pulse at end of every SHOW slot
frame_tick  output  1  one-cycle pulse at end of last digit's SHOW slot

Behaviour:
- Reset (rst=0, async): state=BLANK, cnt=0, idx=0, shadow=0, pending empty, load_ready=1, segment=0, anode=0, sig=0, frame_tick=0.
- All outputs are registered and reflect the state entered on the same edge.
- FSM, two states:
  - BLANK: anode=0, segment=0. cnt counts 0..BLANK-1. At BLANK-1: cnt<=0, go to SHOW and latch en_q=digit_en[idx].
  - SHOW: cnt counts 0..DWELL-1. If en_q=1: anode=1<<idx, segment=decode(shadow[idx]). If en_q=0: anode=0, segment=0; the slot still consumes full timing.
  - At DWELL-1: sig=1, cnt<=0, go to BLANK, idx<=(idx==NDIG-1)?0:idx+1.
- Timing: slot period = BLANK+DWELL cycles. Frame = NDIG*(BLANK+DWELL) cycles (30064 at defaults).
- frame_tick=1 on the SHOW-exit cycle with idx==NDIG-1, coincident with sig.
- Handshake:
  - load_ready = pending empty.
  - Accept (load_valid&load_ready): pending<=load_data, pending full, load_ready=0 next cycle.
  - On a frame_tick cycle with pending full: shadow<=pending, pending empty, load_ready=1 next cycle.
  - Accept on the same cycle as a frame_tick with pending empty: data goes to pending and is committed at the next frame boundary. There is no bypass into shadow.
  - load_valid while load_ready=0 is ignored; the source must hold it.
- digit_en changes mid-slot take effect at the next slot start only.
- Reset mid-frame: immediate blank (anode=0, segment=0); any pending data is discarded.

Optional Feature:
SEVEN_SEG_DIM_EN
- Defined: adds input dim[1:0]. In SHOW, anode/segment are driven only while cnt < (dim+1)*(DWELL/4), and are zero for the rest of the slot. dim is sampled at slot start. DWELL must be divisible by 4.
- Undefined: no dim port; full-slot on-time, exactly as described above.

Decomposition:
- Package seven_seg_pkg:
  - state enum {ST_BLANK, ST_SHOW}
  - SEG_OFF = 7'h00
  - hex font table, 0..F, standard 7-seg encoding, e.g. 0 = 7'h3F, 8 = 7'h7F, F = 7'h71
- Sub-module seven_seg_decode: combinational, 4-bit nibble -> 7-bit segment via the package table. Instanced once and fed by shadow[idx].

Test Plan:
Use NDIG=4, DWELL=8, BLANK=2 (slot 10 cycles, frame 40) unless noted.
- Reset release, digit_en=4'hF, no load -> anode=0 for 2 cycles, then 4'b0001 for 8 cycles with segment=7'h3F. The sequence 0010/0100/1000 follows, sig every 10 cycles, frame_tick at cycle 40.
- Load 16'h8421 at cycle 5 -> load_ready=0 from cycle 6. Frame 1 still shows 0s. From the first SHOW of frame 2: digit0=7'h06 ("1"), digit1=7'h5B ("2"), digit2=7'h66 ("4"), digit3=7'h7F ("8"). load_ready=1 the cycle after frame_tick.
- Second load_valid held while load_ready=0 -> not accepted until load_ready returns. Accepted data then appears one frame later.
- Load accepted on the exact frame_tick cycle -> shadow unchanged at that boundary and updated at the following one.
- digit_en=4'b0101 -> anode never 0010 or 1000. Frame length stays 40 cycles and sig count per frame stays 4.
- rst=0 asserted mid-SHOW of digit2 with pending full -> anode=0 and segment=0 asynchronously. After release the scan restarts at digit0 with shadow=0 and load_ready=1. With SEVEN_SEG_DIM_EN and dim=1: anode high 4 of 8 SHOW cycles.
